// File: rtl/cfg_delay_pkg.sv
// Shared definitions for the configurable delay line.
//   state_t         : RUN (output from RAM/bypass) or FILL (output muted)
//   DEF_DATA_W/ADDR_W: default sample width and RAM address width
//   rd_addr_calc    : modulo-2^addr_w read address (wr_ptr - len)
package cfg_delay_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        FILL = 1'b1
    } state_t;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 10;

    function automatic logic [31:0] rd_addr_calc(input logic [31:0] wr_ptr,
                                                 input logic [31:0] len,
                                                 input int unsigned addr_w);
        logic [31:0] mask;
        mask = (32'd1 << addr_w) - 32'd1;
        return (wr_ptr - len) & mask;
    endfunction

endpackage

// File: rtl/cfg_delay_line_ram.sv
// Simple dual-port, single-clock inferred RAM with registered read.
// Ports:
//   clk              clock
//   wr_en/wr_addr/wr_data  write port
//   rd_en/rd_addr    read port; rd_data updates one clk after rd_en
// Contents are not reset.
module sdp_ram_sync #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/cfg_delay_line.sv
// Sample-qualified delay line: each accepted sample is delayed by
// len_active accepted samples (0 = bypass). After any length change, or
// after reset, the output is muted for L beats so stale RAM is never seen.
// Ports:
//   clk, reset_n      clock, synchronous active-low reset
//   in_valid/in_data  input sample stream
//   delay_len         requested delay, sampled only on accepted beats
//   out_valid         in_valid delayed by one clk
//   out_data          delayed sample, or MUTE_VAL while refilling
//   filling           output muted (valid only with out_valid)
//   len_active        delay currently in effect
//
// state | meaning
// RUN   | output carries RAM read data, or bypass data when L=0
// FILL  | output muted; fill_cnt counts beats toward L
module cfg_delay_line
    import cfg_delay_pkg::*;
#(
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter logic [DATA_W-1:0] MUTE_VAL = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] delay_len,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              filling,
    output logic [ADDR_W-1:0] len_active
);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] fill_cnt, fill_cnt_nxt;
    logic [ADDR_W-1:0] len_nxt, len_eff, cnt_eff;
    logic [ADDR_W-1:0] wr_ptr, rd_addr;
    logic              changed, fill_eff;
    logic              mute_q, mute_nxt;
    logic              filling_nxt;
    logic              bypass_q, bypass_nxt;
    logic [DATA_W-1:0] byp_q, ram_rd;

    // A length change on an accepted beat takes priority over everything,
    // including FILL completion; that beat becomes beat 0 of the new fill.
    always_comb begin
        state_nxt    = state;
        fill_cnt_nxt = fill_cnt;
        len_nxt      = len_active;
        mute_nxt     = mute_q;
        filling_nxt  = filling;
        bypass_nxt   = bypass_q;
        changed      = (delay_len != len_active);
        len_eff      = changed ? delay_len : len_active;
        fill_eff     = changed ? (delay_len != '0) : (state == FILL);
        cnt_eff      = changed ? '0 : fill_cnt;
        if (in_valid) begin
            len_nxt = len_eff;
            if (fill_eff) begin
                mute_nxt    = 1'b1;
                filling_nxt = 1'b1;
                bypass_nxt  = 1'b0;
                if (cnt_eff == len_eff - ONE) begin
                    state_nxt    = RUN;
                    fill_cnt_nxt = '0;
                end else begin
                    state_nxt    = FILL;
                    fill_cnt_nxt = cnt_eff + ONE;
                end
            end else begin
                state_nxt    = RUN;
                fill_cnt_nxt = '0;
                mute_nxt     = 1'b0;
                filling_nxt  = 1'b0;
                bypass_nxt   = (len_eff == '0);
            end
        end
    end

    assign rd_addr = ADDR_W'(rd_addr_calc(32'(wr_ptr), 32'(len_eff), ADDR_W));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= RUN;
            fill_cnt   <= '0;
            len_active <= '0;
            wr_ptr     <= '0;
            out_valid  <= 1'b0;
            mute_q     <= 1'b1;
            filling    <= 1'b0;
            bypass_q   <= 1'b0;
            byp_q      <= '0;
        end else begin
            state      <= state_nxt;
            fill_cnt   <= fill_cnt_nxt;
            len_active <= len_nxt;
            out_valid  <= in_valid;
            mute_q     <= mute_nxt;
            filling    <= filling_nxt;
            bypass_q   <= bypass_nxt;
            if (in_valid) begin
                wr_ptr <= wr_ptr + ONE;
                byp_q  <= in_data;
            end
        end
    end

    sdp_ram_sync #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (in_valid && reset_n),
        .wr_addr (wr_ptr),
        .wr_data (in_data),
        .rd_en   (in_valid && reset_n),
        .rd_addr (rd_addr),
        .rd_data (ram_rd)
    );

    // RAM read data is itself a register, so every term here is registered.
    assign out_data = mute_q   ? MUTE_VAL :
                      bypass_q ? byp_q    : ram_rd;

endmodule

// File: tb/tb_cfg_delay_line.sv
module tb_cfg_delay_line;

    localparam int DW = 16;
    localparam int AW = 10;
    localparam logic [DW-1:0] MUTE = '0;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [AW-1:0] delay_len = '0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          filling;
    logic [AW-1:0] len_active;

    cfg_delay_line #(.DATA_W(DW), .ADDR_W(AW), .MUTE_VAL(MUTE)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .delay_len  (delay_len),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .filling    (filling),
        .len_active (len_active)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: samples since last reset/length change, kept as a list.
    logic [DW-1:0] hist [$];
    int            m_len = 0;
    int            m_k   = 0;
    logic          exp_v;
    logic [DW-1:0] exp_d;
    logic          exp_f;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_beat(input logic [DW-1:0] d, input logic [AW-1:0] len);
        if (int'(len) != m_len) begin
            m_len = int'(len);
            hist.delete();
            m_k = 0;
        end
        hist.push_back(d);
        if (m_k < m_len) begin
            exp_d = MUTE;
            exp_f = 1'b1;
        end else begin
            exp_d = hist[m_k - m_len];
            exp_f = 1'b0;
        end
        m_k++;
    endtask

    task automatic step(input logic v, input logic [DW-1:0] d, input logic [AW-1:0] len);
        in_valid  = v;
        in_data   = d;
        delay_len = len;
        @(posedge clk);
        exp_v = v;
        if (v) model_beat(d, len);
        @(negedge clk);
        check("out_valid", 32'(out_valid), 32'(exp_v));
        if (exp_v) begin
            check("out_data", 32'(out_data), 32'(exp_d));
            check("filling", 32'(filling), 32'(exp_f));
        end
        check("len_active", 32'(len_active), 32'(m_len));
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'hBEEF;
        delay_len = 10'd9;
        @(posedge clk);
        hist.delete();
        m_len = 0;
        m_k   = 0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'(MUTE));
        check("rst_filling", 32'(filling), 32'd0);
        check("rst_len_active", 32'(len_active), 32'd0);
        reset_n  = 1'b1;
        in_valid = 1'b0;
    endtask

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic [AW-1:0] len;
        logic          ev;
        logic [DW-1:0] ed;
        logic          ef;
    } vec_t;

    initial begin
        vec_t          tbl [10];
        logic [DW-1:0] ramp;
        int            muted;

        for (int i = 0; i < 10; i++) begin
            tbl[i].v   = 1'b1;
            tbl[i].d   = DW'(i + 1);
            tbl[i].len = 10'd4;
            tbl[i].ev  = 1'b1;
            tbl[i].ed  = (i < 4) ? MUTE : DW'(i - 3);
            tbl[i].ef  = (i < 4);
        end

        @(negedge clk);
        do_reset();
        do_reset();

        // L=4 ramp, table-driven
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].len);
            check("tbl_valid", 32'(out_valid), 32'(tbl[i].ev));
            check("tbl_data", 32'(out_data), 32'(tbl[i].ed));
            check("tbl_filling", 32'(filling), 32'(tbl[i].ef));
        end
        step(1'b0, 16'h0, 10'd4);

        // bypass with random gaps
        ramp = 16'd100;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(2, 0) != 0) begin
                step(1'b1, ramp, 10'd0);
                check("byp_filling", 32'(filling), 32'd0);
                ramp++;
            end else begin
                step(1'b0, 16'($urandom), 10'd0);
            end
        end

        // maximum length, wraps pointer
        for (int i = 0; i < 3000; i++) step(1'b1, 16'($urandom), 10'd1023);

        // L=8 then switch to 3
        for (int i = 0; i < 20; i++) step(1'b1, 16'($urandom), 10'd8);
        muted = 0;
        for (int i = 0; i < 15; i++) begin
            step(1'b1, 16'($urandom), 10'd3);
            if (filling) muted++;
        end
        check("switch_muted_beats", 32'(muted), 32'd3);
        check("switch_len_active", 32'(len_active), 32'd3);

        // L=5 with a sample every third cycle; delay_len wiggles on idle cycles
        for (int i = 0; i < 90; i++) begin
            if (i % 3 == 0) step(1'b1, 16'($urandom), 10'd5);
            else            step(1'b0, 16'($urandom), 10'($urandom));
        end

        // reset in the middle of a FILL at L=6
        for (int i = 0; i < 20; i++) step(1'b1, 16'(16'h1000 + i), 10'd2);
        for (int i = 0; i < 3; i++)  step(1'b1, 16'(16'h2000 + i), 10'd6);
        do_reset();
        muted = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 16'(16'h3000 + i), 10'd6);
            if (filling) muted++;
        end
        check("post_reset_muted", 32'(muted), 32'd6);

        // random stress over small lengths
        for (int i = 0; i < 600; i++) begin
            logic [AW-1:0] lens [5];
            lens[0] = 10'd0; lens[1] = 10'd1; lens[2] = 10'd2;
            lens[3] = 10'd7; lens[4] = 10'd31;
            if ($urandom_range(49, 0) == 0) delay_len = lens[$urandom_range(4, 0)];
            step(1'($urandom_range(1, 0)), 16'($urandom), delay_len);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
